// File: rtl/ascon_pkg.sv
// Shared types and round constants for the ASCON permutation controller.
package ascon_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLEAR,
    S_INIT,
    S_WAIT_AD,
    S_AD,
    S_WAIT_PT,
    S_PT,
    S_FINAL,
    S_DONE
  } t_fsm_state;

  typedef enum logic [1:0] {
    RC_HOLD,
    RC_CLEAR,
    RC_LOAD,
    RC_INC
  } t_round_cmd;

  localparam logic [3:0] C_ROUND_PA_START = 4'd0;
  localparam logic [3:0] C_ROUND_PB_START = 4'd6;
  localparam logic [3:0] C_ROUND_LAST     = 4'd11;

endpackage

// File: rtl/ascon_fsm_round_counter.sv
// Permutation round counter: clears, loads a start round, increments and
// saturates at the last round, flagging it.
module round_counter
  import ascon_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] cmd_i,
  input  logic [3:0] load_value_i,
  output logic [3:0] round_o,
  output logic       last_o
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  // A load is visible in the same cycle, so a data transfer already runs
  // its first round; the register then holds the following round.
  always_comb begin
    round_o = count_q;
    count_d = count_q;
    case (cmd_i)
      RC_CLEAR: count_d = C_ROUND_PA_START;
      RC_LOAD: begin
        round_o = load_value_i;
        count_d = load_value_i + 4'd1;
      end
      RC_INC: begin
        if (count_q != C_ROUND_LAST) begin
          count_d = count_q + 4'd1;
        end
      end
      default: count_d = count_q;
    endcase
    last_o = (round_o == C_ROUND_LAST);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= C_ROUND_PA_START;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ascon_fsm.sv
// ASCON encryption controller: sequences init, associated data, plaintext
// blocks and finalisation over a shared permutation datapath.
module ascon_fsm
  import ascon_pkg::*;
#(
  parameter int G_NUM_PT_BLOCKS = 4
)
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_start,
  input  logic       i_data_valid,
  output logic       o_ready,
  output logic       o_cipher_valid,
  output logic       o_done,
  output logic       o_busy,
  output logic       o_sys_enable,
  output logic       o_mux_select,
  output logic       o_enable_xor_key_begin,
  output logic       o_enable_xor_data_begin,
  output logic       o_enable_xor_key_end,
  output logic       o_enable_xor_lsb_end,
  output logic       o_enable_cipher_reg,
  output logic       o_enable_tag_reg,
  output logic       o_enable_state_reg,
  output logic [3:0] o_round
);

  t_fsm_state state_q;
  t_fsm_state state_d;
  logic [3:0] block_q;
  logic [3:0] block_d;
  t_round_cmd roundCmd;
  logic [3:0] roundLoad;
  logic       roundLast;
  logic       lastBlock;

  assign lastBlock = (block_q == 4'(G_NUM_PT_BLOCKS - 1));

  round_counter u_round_counter (
    .clock        (clock),
    .reset_n      (reset_n),
    .cmd_i        (roundCmd),
    .load_value_i (roundLoad),
    .round_o      (o_round),
    .last_o       (roundLast)
  );

  // Counter command depends only on state and inputs, never on the round.
  always_comb begin
    roundCmd  = RC_HOLD;
    roundLoad = C_ROUND_PB_START;
    case (state_q)
      S_CLEAR, S_DONE:             roundCmd = RC_CLEAR;
      S_INIT, S_AD, S_PT, S_FINAL: roundCmd = RC_INC;
      S_WAIT_AD: begin
        if (i_data_valid) roundCmd = RC_LOAD;
      end
      S_WAIT_PT: begin
        if (i_data_valid) begin
          roundCmd = RC_LOAD;
          if (lastBlock) roundLoad = C_ROUND_PA_START;
        end
      end
      default: roundCmd = RC_HOLD;
    endcase
  end

  always_comb begin
    state_d                 = state_q;
    block_d                 = block_q;
    o_ready                 = 1'b0;
    o_sys_enable            = 1'b1;
    o_mux_select            = 1'b0;
    o_enable_xor_key_begin  = 1'b0;
    o_enable_xor_data_begin = 1'b0;
    o_enable_xor_key_end    = 1'b0;
    o_enable_xor_lsb_end    = 1'b0;
    o_enable_cipher_reg     = 1'b0;
    o_enable_tag_reg        = 1'b0;
    o_enable_state_reg      = 1'b0;
    o_busy                  = (state_q != S_IDLE);
    o_done                  = (state_q == S_DONE);
    // The first round after a plaintext transfer marks a fresh cipher block.
    o_cipher_valid          = ((state_q == S_PT) && (o_round == C_ROUND_PB_START + 4'd1)) ||
                              ((state_q == S_FINAL) && (o_round == C_ROUND_PA_START + 4'd1));
    case (state_q)
      S_IDLE: begin
        if (i_start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        o_sys_enable = 1'b0;
        block_d      = '0;
        state_d      = S_INIT;
      end
      S_INIT: begin
        o_enable_state_reg = 1'b1;
        o_mux_select       = (o_round != C_ROUND_PA_START);
        if (roundLast) begin
          o_enable_xor_key_end = 1'b1;
          state_d              = S_WAIT_AD;
        end
      end
      S_WAIT_AD: begin
        o_ready = 1'b1;
        if (i_data_valid) begin
          o_mux_select            = 1'b1;
          o_enable_xor_data_begin = 1'b1;
          o_enable_state_reg      = 1'b1;
          state_d                 = S_AD;
        end
      end
      S_AD: begin
        o_enable_state_reg = 1'b1;
        o_mux_select       = 1'b1;
        if (roundLast) begin
          o_enable_xor_lsb_end = 1'b1;
          state_d              = S_WAIT_PT;
        end
      end
      S_WAIT_PT: begin
        o_ready = 1'b1;
        if (i_data_valid) begin
          o_mux_select            = 1'b1;
          o_enable_xor_data_begin = 1'b1;
          o_enable_cipher_reg     = 1'b1;
          o_enable_state_reg      = 1'b1;
          block_d                 = block_q + 4'd1;
          if (lastBlock) begin
            o_enable_xor_key_begin = 1'b1;
            state_d                = S_FINAL;
          end else begin
            state_d = S_PT;
          end
        end
      end
      S_PT: begin
        o_enable_state_reg = 1'b1;
        o_mux_select       = 1'b1;
        if (roundLast) state_d = S_WAIT_PT;
      end
      S_FINAL: begin
        o_enable_state_reg = 1'b1;
        o_mux_select       = 1'b1;
        if (roundLast) begin
          o_enable_xor_key_end = 1'b1;
          o_enable_tag_reg     = 1'b1;
          state_d              = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      block_q <= '0;
    end else begin
      state_q <= state_d;
      block_q <= block_d;
    end
  end

endmodule

// File: tb/tb_ascon_fsm.sv
// Randomized self-checking bench for ascon_fsm: a phase-level model builds the
// expected per-cycle output trace of each message, which is replayed on the DUT.
module tb_ascon_fsm;

  typedef struct packed {
    logic       ready;
    logic       cipherValid;
    logic       done;
    logic       busy;
    logic       sysEnable;
    logic       muxSelect;
    logic       xorKeyBegin;
    logic       xorDataBegin;
    logic       xorKeyEnd;
    logic       xorLsbEnd;
    logic       cipherReg;
    logic       tagReg;
    logic       stateReg;
    logic [3:0] round;
  } outVec_t;

  typedef enum int {PH_IDLE, PH_CLEAR, PH_INIT, PH_WAIT, PH_XFER, PH_AD, PH_PT, PH_FINAL, PH_DONE} phase_t;

  typedef struct {
    logic    start;
    logic    valid;
    outVec_t exp;
    logic    muxCare;
    phase_t  phase;
  } entry_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic start4 = 1'b0, valid4 = 1'b0, start1 = 1'b0, valid1 = 1'b0;
  outVec_t obs4, obs1;
  outVec_t resetVec;
  entry_t msgQ[$];
  int checks = 0;
  int errors = 0;
  bit monOn = 1'b0;
  logic taken4, taken1;

  always #5 clock = ~clock;

  ascon_fsm #(.G_NUM_PT_BLOCKS(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .i_start(start4), .i_data_valid(valid4),
    .o_ready(obs4.ready), .o_cipher_valid(obs4.cipherValid), .o_done(obs4.done),
    .o_busy(obs4.busy), .o_sys_enable(obs4.sysEnable), .o_mux_select(obs4.muxSelect),
    .o_enable_xor_key_begin(obs4.xorKeyBegin), .o_enable_xor_data_begin(obs4.xorDataBegin),
    .o_enable_xor_key_end(obs4.xorKeyEnd), .o_enable_xor_lsb_end(obs4.xorLsbEnd),
    .o_enable_cipher_reg(obs4.cipherReg), .o_enable_tag_reg(obs4.tagReg),
    .o_enable_state_reg(obs4.stateReg), .o_round(obs4.round)
  );

  ascon_fsm #(.G_NUM_PT_BLOCKS(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .i_start(start1), .i_data_valid(valid1),
    .o_ready(obs1.ready), .o_cipher_valid(obs1.cipherValid), .o_done(obs1.done),
    .o_busy(obs1.busy), .o_sys_enable(obs1.sysEnable), .o_mux_select(obs1.muxSelect),
    .o_enable_xor_key_begin(obs1.xorKeyBegin), .o_enable_xor_data_begin(obs1.xorDataBegin),
    .o_enable_xor_key_end(obs1.xorKeyEnd), .o_enable_xor_lsb_end(obs1.xorLsbEnd),
    .o_enable_cipher_reg(obs1.cipherReg), .o_enable_tag_reg(obs1.tagReg),
    .o_enable_state_reg(obs1.stateReg), .o_round(obs1.round)
  );

  // Remember whether the last edge accepted a start: only then may sys_enable drop.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      taken4 <= 1'b0;
      taken1 <= 1'b0;
    end else begin
      taken4 <= (obs4.busy === 1'b0) && (start4 === 1'b1);
      taken1 <= (obs1.busy === 1'b0) && (start1 === 1'b1);
    end
  end

  always @(negedge clock) begin
    if (monOn) begin
      checks = checks + 4;
      if (!(obs4.round <= 4'd11)) begin errors++; $display("[TB] FAIL assert_round4: got %0d want <=11", obs4.round); end
      if (!(obs1.round <= 4'd11)) begin errors++; $display("[TB] FAIL assert_round1: got %0d want <=11", obs1.round); end
      if (obs4.sysEnable !== !taken4) begin errors++; $display("[TB] FAIL assert_sysen4: got %b want %b", obs4.sysEnable, !taken4); end
      if (obs1.sysEnable !== !taken1) begin errors++; $display("[TB] FAIL assert_sysen1: got %b want %b", obs1.sysEnable, !taken1); end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic pushCycle(input logic st, input logic vl, input outVec_t v, input logic mc, input phase_t ph);
    entry_t e;
    e.start = st; e.valid = vl; e.exp = v; e.muxCare = mc; e.phase = ph;
    msgQ.push_back(e);
  endtask

  function automatic logic rnd();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic outVec_t busyBase();
    outVec_t v = '0;
    v.busy = 1'b1;
    v.sysEnable = 1'b1;
    return v;
  endfunction

  task automatic pushStalls(input int n, input bit rs);
    outVec_t v;
    for (int i = 0; i < n; i++) begin
      v = busyBase(); v.ready = 1'b1; v.round = 4'd11;
      pushCycle(rs ? rnd() : 1'b0, 1'b0, v, 1'b1, PH_WAIT);
    end
  endtask

  // Expected trace of one message: phases and round ranges straight from the protocol.
  task automatic buildMessage(input int nBlocks, input int maxStall, input int adStall, input bit rs);
    outVec_t v;
    bit last;
    msgQ.delete();
    v = '0; v.sysEnable = 1'b1;
    pushCycle(1'b1, 1'b1, v, 1'b1, PH_IDLE);
    v = busyBase(); v.sysEnable = 1'b0;
    pushCycle(rs ? rnd() : 1'b0, rnd(), v, 1'b1, PH_CLEAR);
    for (int r = 0; r <= 11; r++) begin
      v = busyBase(); v.stateReg = 1'b1; v.muxSelect = (r != 0); v.xorKeyEnd = (r == 11); v.round = 4'(r);
      pushCycle(rs ? rnd() : 1'b0, rnd(), v, 1'b1, PH_INIT);
    end
    pushStalls((adStall >= 0) ? adStall : int'($urandom_range(0, maxStall)), rs);
    v = busyBase(); v.ready = 1'b1; v.round = 4'd6; v.muxSelect = 1'b1; v.xorDataBegin = 1'b1; v.stateReg = 1'b1;
    pushCycle(rs ? rnd() : 1'b0, 1'b1, v, 1'b1, PH_XFER);
    for (int r = 7; r <= 11; r++) begin
      v = busyBase(); v.stateReg = 1'b1; v.xorLsbEnd = (r == 11); v.round = 4'(r);
      pushCycle(rs ? rnd() : 1'b0, rnd(), v, 1'b0, PH_AD);
    end
    for (int b = 0; b < nBlocks; b++) begin
      last = (b == nBlocks - 1);
      pushStalls(int'($urandom_range(0, maxStall)), rs);
      v = busyBase(); v.ready = 1'b1; v.muxSelect = 1'b1; v.xorDataBegin = 1'b1; v.cipherReg = 1'b1;
      v.stateReg = 1'b1; v.xorKeyBegin = last; v.round = last ? 4'd0 : 4'd6;
      pushCycle(rs ? rnd() : 1'b0, 1'b1, v, 1'b1, PH_XFER);
      if (!last) begin
        for (int r = 7; r <= 11; r++) begin
          v = busyBase(); v.stateReg = 1'b1; v.cipherValid = (r == 7); v.round = 4'(r);
          pushCycle(rs ? rnd() : 1'b0, rnd(), v, 1'b0, PH_PT);
        end
      end else begin
        for (int r = 1; r <= 11; r++) begin
          v = busyBase(); v.stateReg = 1'b1; v.cipherValid = (r == 1);
          v.xorKeyEnd = (r == 11); v.tagReg = (r == 11); v.round = 4'(r);
          pushCycle(rs ? rnd() : 1'b0, rnd(), v, 1'b0, PH_FINAL);
        end
      end
    end
    v = busyBase(); v.done = 1'b1; v.round = 4'd11;
    pushCycle(rs ? rnd() : 1'b0, rnd(), v, 1'b1, PH_DONE);
    v = '0; v.sysEnable = 1'b1;
    pushCycle(1'b0, rnd(), v, 1'b1, PH_IDLE);
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (obs4 !== resetVec) begin errors++; $display("[TB] FAIL reset_dut4: got %h want %h", obs4, resetVec); end
    checks++;
    if (obs1 !== resetVec) begin errors++; $display("[TB] FAIL reset_dut1: got %h want %h", obs1, resetVec); end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    monOn = 1'b1;
    checks++;
    if (obs4 !== resetVec) begin errors++; $display("[TB] FAIL idle_after_reset: got %h want %h", obs4, resetVec); end
  endtask

  task automatic test_full_message();
    outVec_t care;
    int cvCount = 0, tagCycle = -1, doneCycle = -1;
    buildMessage(4, 0, 0, 1'b0);
    for (int k = 0; k < msgQ.size(); k++) begin
      start4 = msgQ[k].start; valid4 = msgQ[k].valid;
      @(negedge clock);
      care = '1; care.muxSelect = msgQ[k].muxCare;
      checks++;
      if ((obs4 & care) !== (msgQ[k].exp & care)) begin
        errors++; $display("[TB] FAIL full_msg cycle %0d: got %h want %h", k, obs4, msgQ[k].exp);
      end
      if (obs4.cipherValid === 1'b1) cvCount++;
      if (obs4.tagReg === 1'b1 && tagCycle < 0) tagCycle = k;
      if (obs4.done === 1'b1 && doneCycle < 0) doneCycle = k;
      @(posedge clock); #1;
    end
    start4 = 1'b0; valid4 = 1'b0;
    checks++;
    if (cvCount !== 4) begin errors++; $display("[TB] FAIL cipher_valid_count: got %0d want 4", cvCount); end
    checks++;
    if (tagCycle !== 49) begin errors++; $display("[TB] FAIL tag_cycle: got %0d want 49", tagCycle); end
    checks++;
    if (doneCycle !== 50) begin errors++; $display("[TB] FAIL done_cycle: got %0d want 50", doneCycle); end
  endtask

  task automatic test_stall_random(input int nMsg);
    outVec_t care;
    for (int m = 0; m < nMsg; m++) begin
      buildMessage(4, 6, (m == 0) ? 10 : -1, 1'b0);
      for (int k = 0; k < msgQ.size(); k++) begin
        start4 = msgQ[k].start; valid4 = msgQ[k].valid;
        @(negedge clock);
        care = '1; care.muxSelect = msgQ[k].muxCare;
        checks++;
        if ((obs4 & care) !== (msgQ[k].exp & care)) begin
          errors++; $display("[TB] FAIL stall msg %0d cycle %0d: got %h want %h", m, k, obs4, msgQ[k].exp);
        end
        @(posedge clock); #1;
      end
    end
    start4 = 1'b0; valid4 = 1'b0;
  endtask

  task automatic test_single_block();
    outVec_t care;
    buildMessage(1, 3, -1, 1'b0);
    for (int k = 0; k < msgQ.size(); k++) begin
      start1 = msgQ[k].start; valid1 = msgQ[k].valid;
      @(negedge clock);
      care = '1; care.muxSelect = msgQ[k].muxCare;
      checks++;
      if ((obs1 & care) !== (msgQ[k].exp & care)) begin
        errors++; $display("[TB] FAIL single_block cycle %0d: got %h want %h", k, obs1, msgQ[k].exp);
      end
      @(posedge clock); #1;
    end
    start1 = 1'b0; valid1 = 1'b0;
  endtask

  task automatic test_start_ignored();
    outVec_t care;
    int doneCycle = -1;
    buildMessage(4, 0, 0, 1'b1);
    for (int k = 0; k < msgQ.size(); k++) begin
      start4 = msgQ[k].start; valid4 = msgQ[k].valid;
      @(negedge clock);
      care = '1; care.muxSelect = msgQ[k].muxCare;
      checks++;
      if ((obs4 & care) !== (msgQ[k].exp & care)) begin
        errors++; $display("[TB] FAIL start_ignored cycle %0d: got %h want %h", k, obs4, msgQ[k].exp);
      end
      if (obs4.done === 1'b1 && doneCycle < 0) doneCycle = k;
      @(posedge clock); #1;
    end
    start4 = 1'b0; valid4 = 1'b0;
    checks++;
    if (doneCycle !== 50) begin errors++; $display("[TB] FAIL start_ignored_done: got %0d want 50", doneCycle); end
  endtask

  task automatic test_async_reset();
    outVec_t care;
    int cut = -1;
    buildMessage(4, 2, -1, 1'b0);
    for (int k = 0; k < msgQ.size(); k++) begin
      if (cut < 0 && msgQ[k].phase == PH_PT && msgQ[k].exp.round == 4'd9) cut = k;
    end
    for (int k = 0; k < cut; k++) begin
      start4 = msgQ[k].start; valid4 = msgQ[k].valid;
      @(negedge clock);
      care = '1; care.muxSelect = msgQ[k].muxCare;
      checks++;
      if ((obs4 & care) !== (msgQ[k].exp & care)) begin
        errors++; $display("[TB] FAIL pre_reset cycle %0d: got %h want %h", k, obs4, msgQ[k].exp);
      end
      @(posedge clock); #1;
    end
    start4 = msgQ[cut].start; valid4 = msgQ[cut].valid;
    #1;
    checks++;
    if (obs4.round !== 4'd9) begin errors++; $display("[TB] FAIL pt_round9: got %0d want 9", obs4.round); end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (obs4 !== resetVec) begin errors++; $display("[TB] FAIL async_reset_now: got %h want %h", obs4, resetVec); end
    @(posedge clock); #1;
    checks++;
    if (obs4 !== resetVec) begin errors++; $display("[TB] FAIL async_reset_held: got %h want %h", obs4, resetVec); end
    @(negedge clock);
    reset_n = 1'b1;
    start4 = 1'b0; valid4 = 1'b0;
    @(posedge clock); #1;
    buildMessage(4, 0, 0, 1'b0);
    for (int k = 0; k < msgQ.size(); k++) begin
      start4 = msgQ[k].start; valid4 = msgQ[k].valid;
      @(negedge clock);
      care = '1; care.muxSelect = msgQ[k].muxCare;
      checks++;
      if ((obs4 & care) !== (msgQ[k].exp & care)) begin
        errors++; $display("[TB] FAIL post_reset cycle %0d: got %h want %h", k, obs4, msgQ[k].exp);
      end
      @(posedge clock); #1;
    end
    start4 = 1'b0; valid4 = 1'b0;
  endtask

  initial begin
    resetVec = '0;
    resetVec.sysEnable = 1'b1;
    test_reset();
    test_full_message();
    test_stall_random(3);
    test_single_block();
    test_start_ignored();
    test_async_reset();
    monOn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
